mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one single-port instruction/data memory between the fetch path (program counter / instruction ROM side) and the load_store_unit.
- Arbitrates requests and allows exactly one outstanding memory transaction.
- Routes each response back to the requester that owns the transaction.
- Data accesses have priority, with a bounded starvation guard so fetch always makes progress.

Parameters:
DATA_WIDTH, 32, width of data buses
ADDR_WIDTH, 32, width of address buses
MAX_DATA_STREAK, 4, max consecutive data grants while fetch is waiting (range 1..15)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
instr_req_i  input  1  fetch request
instr_addr_i  input  ADDR_WIDTH  fetch address
instr_gnt_o  output  1  fetch request accepted (1-cycle pulse)
instr_rvalid_o  output  1  fetch response valid
instr_rdata_o  output  DATA_WIDTH  fetched instruction
data_req_i  input  1  LSU request
data_we_i  input  1  1 = store, 0 = load
data_be_i  input  DATA_WIDTH/8  byte enables
data_addr_i  input  ADDR_WIDTH  LSU address
data_wdata_i  input  DATA_WIDTH  store data
data_gnt_o  output  1  LSU request accepted (1-cycle pulse)
data_rvalid_o  output  1  LSU response valid (loads and stores)
data_rdata_o  output  DATA_WIDTH  load data
mem_req_o  output  1  memory request
mem_we_o  output  1  memory write enable
mem_be_o  output  DATA_WIDTH/8  memory byte enables
mem_addr_o  output  ADDR_WIDTH  memory address
mem_wdata_o  output  DATA_WIDTH  memory write data
mem_gnt_i  input  1  memory accepted request
mem_rvalid_i  input  1  memory response valid
mem_rdata_i  input  DATA_WIDTH  memory read data
busy_o  output  1  FSM not in IDLE
proto_err_o  output  1  1-cycle pulse on spurious mem_rvalid_i

Behaviour:
- The clock port is clk. The reset port is rst: one clock, synchronous, active-high.
- Reset:
  - FSM goes to IDLE; streak counter = 0.
  - Holding regs and owner flag = 0.
  - All outputs are 0.
  - mem_*_o must be 0 in the cycle after rst is sampled high.
- FSM states: IDLE, REQ, WAIT_RSP.
- IDLE:
  - If any req_i is high, pick a winner (combinational, same cycle) and pulse the winner's gnt_o in that cycle.
  - On that edge, latch the winner's addr/we/be/wdata and owner into holding regs; next state is REQ.
  - A fetch latches we=0, be=all ones, wdata=0.
- Arbitration:
  - Data wins over fetch, unless streak == MAX_DATA_STREAK and instr_req_i is high; then fetch wins.
  - Streak increments on a data grant while instr_req_i is high (saturating at MAX_DATA_STREAK).
  - Streak clears on any fetch grant.
  - Streak is unchanged on a data grant with instr_req_i low.
- REQ:
  - mem_req_o = 1 and mem_* are driven from the holding regs; they stay stable until mem_gnt_i.
  - On mem_gnt_i, next state is WAIT_RSP.
- WAIT_RSP:
  - mem_req_o = 0.
  - On mem_rvalid_i, the owner's rvalid_o = 1 and rdata_o = mem_rdata_i, combinationally in the same cycle; next state is IDLE.
  - The non-owner's rvalid_o stays 0; both rdata_o are 0 when not valid.
  - Stores also complete via mem_rvalid_i.
- Minimum latency (gnt_o at cycle N, zero-wait memory):
  - mem_req_o at N+1 (mem_gnt_i at N+1).
  - rvalid_o at N+2.
  - Next gnt_o possible at N+3.
- Requesters may drop req_i after gnt_o; the holding regs keep the transaction intact.
- In REQ or WAIT_RSP, gnt_o = 0 regardless of req_i; no queuing.
- Spurious response: mem_rvalid_i in IDLE or REQ produces a 1-cycle proto_err_o pulse; the response is dropped and no rvalid_o is asserted.
- Reset mid-transaction aborts it with no rvalid_o. A late mem_rvalid_i afterwards raises proto_err_o.
- busy_o = (state != IDLE).

Test Plan:
- Single fetch, zero-wait memory: instr_req_i at cycle 0, addr 0x0000_0010, mem_rdata 0x0000_0513.
  -> instr_gnt_o at 0; mem_req_o and mem_addr_o=0x10 at 1; instr_rvalid_o with 0x0000_0513 at 2; busy_o low at 3.
- Simultaneous requests: instr_req_i and data_req_i both high (data load at 0x100).
  -> data_gnt_o first; instr_gnt_o on the next IDLE cycle (cycle 3); data_rvalid_o never coincides with instr_rvalid_o.
- Starvation guard: data_req_i and instr_req_i held high, MAX_DATA_STREAK=4.
  -> exactly 4 data grants, then 1 fetch grant, then data again; the pattern repeats.
- Store with wait states: data_we_i=1, be=4'b0011, wdata 0xDEAD_BEEF; mem_gnt_i delayed 3 cycles.
  -> mem_* held stable for all 3 REQ cycles; data_rvalid_o on mem_rvalid_i; data_rdata_o = 0 when not valid.
- Spurious response: mem_rvalid_i pulsed in IDLE.
  -> proto_err_o = 1 for exactly 1 cycle; no rvalid_o asserted; state stays IDLE.
- Reset in WAIT_RSP: rst high for 1 cycle.
  -> all outputs 0 next cycle; a subsequent mem_rvalid_i gives proto_err_o and no rvalid_o.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one single-port memory between the instruction fetch path and the
// load/store unit. Only one memory transaction is in flight at a time; the
// response is steered back to whichever requester owns it. Data accesses win
// arbitration, but after MAX_DATA_STREAK back-to-back data grants with fetch
// waiting, fetch is granted once so the core keeps making forward progress.

module mem_bus_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                    clk,
    input  logic                    rst,

    // Fetch side
    input  logic                    instr_req_i,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,

    // Load/store side
    input  logic                    data_req_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,

    // Memory side
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,

    // Status
    output logic                    busy_o,
    output logic                    proto_err_o
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    // The streak counter is 4 bits wide, which covers the legal 1..15 range.
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } state_e;

    state_e                  state_q,  state_d;
    logic [3:0]              streak_q, streak_d;
    logic                    owner_q,  owner_d;   // 1 = data owns the transaction
    logic [ADDR_WIDTH-1:0]   addr_q,   addr_d;
    logic                    we_q,     we_d;
    logic [BE_WIDTH-1:0]     be_q,     be_d;
    logic [DATA_WIDTH-1:0]   wdata_q,  wdata_d;
    logic                    proto_err_q, proto_err_d;

    logic                    fetch_win_s;
    logic                    data_win_s;

    // Arbitration: data has priority unless the starvation guard has tripped.
    always_comb begin
        fetch_win_s = 1'b0;
        data_win_s  = 1'b0;
        if (instr_req_i && (!data_req_i || (streak_q == STREAK_MAX))) begin
            fetch_win_s = 1'b1;
        end else if (data_req_i) begin
            data_win_s = 1'b1;
        end else begin
            fetch_win_s = 1'b0;
            data_win_s  = 1'b0;
        end
    end

    // State register, holding registers, streak counter and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            streak_q    <= 4'd0;
            owner_q     <= 1'b0;
            addr_q      <= {ADDR_WIDTH{1'b0}};
            we_q        <= 1'b0;
            be_q        <= {BE_WIDTH{1'b0}};
            wdata_q     <= {DATA_WIDTH{1'b0}};
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Next-state logic and all FSM-dependent outputs.
    always_comb begin
        state_d        = state_q;
        streak_d       = streak_q;
        owner_d        = owner_q;
        addr_d         = addr_q;
        we_d           = we_q;
        be_d           = be_q;
        wdata_d        = wdata_q;
        proto_err_d    = 1'b0;

        instr_gnt_o    = 1'b0;
        data_gnt_o     = 1'b0;
        instr_rvalid_o = 1'b0;
        data_rvalid_o  = 1'b0;
        instr_rdata_o  = {DATA_WIDTH{1'b0}};
        data_rdata_o   = {DATA_WIDTH{1'b0}};

        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_be_o       = {BE_WIDTH{1'b0}};
        mem_addr_o     = {ADDR_WIDTH{1'b0}};
        mem_wdata_o    = {DATA_WIDTH{1'b0}};

        case (state_q)
            IDLE: begin
                // Nothing is outstanding, so any response here is spurious.
                proto_err_d = mem_rvalid_i;
                if (fetch_win_s) begin
                    instr_gnt_o = 1'b1;
                    owner_d     = 1'b0;
                    addr_d      = instr_addr_i;
                    we_d        = 1'b0;
                    be_d        = {BE_WIDTH{1'b1}};
                    wdata_d     = {DATA_WIDTH{1'b0}};
                    streak_d    = 4'd0;
                    state_d     = REQ;
                end else if (data_win_s) begin
                    data_gnt_o  = 1'b1;
                    owner_d     = 1'b1;
                    addr_d      = data_addr_i;
                    we_d        = data_we_i;
                    be_d        = data_be_i;
                    wdata_d     = data_wdata_i;
                    // Only count grants that actually made fetch wait.
                    if (instr_req_i && (streak_q != STREAK_MAX)) begin
                        streak_d = streak_q + 4'd1;
                    end else begin
                        streak_d = streak_q;
                    end
                    state_d     = REQ;
                end else begin
                    state_d     = IDLE;
                end
            end

            REQ: begin
                // Present the latched transaction until the memory takes it.
                mem_req_o   = 1'b1;
                mem_we_o    = we_q;
                mem_be_o    = be_q;
                mem_addr_o  = addr_q;
                mem_wdata_o = wdata_q;
                // The request has not been accepted yet, so no response is due.
                proto_err_d = mem_rvalid_i;
                if (mem_gnt_i) begin
                    state_d = WAIT_RSP;
                end else begin
                    state_d = REQ;
                end
            end

            WAIT_RSP: begin
                if (mem_rvalid_i) begin
                    if (owner_q) begin
                        data_rvalid_o  = 1'b1;
                        data_rdata_o   = mem_rdata_i;
                    end else begin
                        instr_rvalid_o = 1'b1;
                        instr_rdata_o  = mem_rdata_i;
                    end
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_RSP;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o      = (state_q != IDLE);
    assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a behavioural memory (configurable
// grant delay) and a scoreboard of expected responses per grant.

module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o, instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic        data_gnt_o, data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        busy_o, proto_err_o;

    int n_cmp = 0;
    int n_err = 0;

    mem_bus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_DATA_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o), .proto_err_o(proto_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- memory model ----------------
    int          gnt_delay = 0;
    int          req_cycles = 0;
    bit          rsp_pending = 1'b0;
    bit          mute = 1'b0;
    bit          spur = 1'b0;
    logic [31:0] rdata_lat = 32'h0;
    logic [31:0] mem_model [256];
    bit          mem_wr    [256];
    logic [31:0] ref_mem   [256];
    bit          ref_wr    [256];

    function automatic logic [31:0] init_word(input int idx);
        if (idx == 4)  return 32'h0000_0513;
        if (idx == 64) return 32'hCAFE_0100;
        return 32'h1000_0000 | 32'(idx * 4);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int idx;
        idx = int'(a[9:2]);
        return mem_wr[idx] ? mem_model[idx] : init_word(idx);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        int idx;
        idx = int'(a[9:2]);
        return ref_wr[idx] ? ref_mem[idx] : init_word(idx);
    endfunction

    assign mem_gnt_i    = mem_req_o && (req_cycles >= gnt_delay);
    assign mem_rvalid_i = (rsp_pending && !mute) || spur;
    assign mem_rdata_i  = (rsp_pending && !mute) ? rdata_lat : 32'hBAD0_BAD0;

    // Memory: accept on req&gnt, respond the following cycle.
    always @(posedge clk) begin
        if (rst) begin
            rsp_pending <= 1'b0;
            req_cycles  <= 0;
        end else begin
            rsp_pending <= mem_req_o && mem_gnt_i;
            if (mem_req_o && !mem_gnt_i) req_cycles <= req_cycles + 1;
            else                         req_cycles <= 0;
            if (mem_req_o && mem_gnt_i) begin
                if (mem_we_o) begin
                    mem_model[mem_addr_o[9:2]] <= merge(model_read(mem_addr_o), mem_wdata_o, mem_be_o);
                    mem_wr[mem_addr_o[9:2]]    <= 1'b1;
                    rdata_lat <= 32'h0;
                end else begin
                    rdata_lat <= model_read(mem_addr_o);
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic [32:0] sb [$];   // {owner_is_data, expected rdata}
    byte         glog [$];
    bit          log_en = 1'b0;

    // Push expectations on grants, pop and compare on responses.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (instr_gnt_o) begin
                sb.push_back({1'b0, ref_read(instr_addr_i)});
                if (log_en) glog.push_back("I");
            end
            if (data_gnt_o) begin
                if (data_we_i) begin
                    ref_mem[data_addr_i[9:2]] <= merge(ref_read(data_addr_i), data_wdata_i, data_be_i);
                    ref_wr[data_addr_i[9:2]]  <= 1'b1;
                    sb.push_back({1'b1, 32'h0});
                end else begin
                    sb.push_back({1'b1, ref_read(data_addr_i)});
                end
                if (log_en) glog.push_back("D");
            end
            if (instr_rvalid_o || data_rvalid_o) begin
                logic [32:0] e;
                check("rvalid_exclusive", 32'(instr_rvalid_o & data_rvalid_o), 32'h0);
                if (sb.size() == 0) begin
                    check("rsp_without_grant", 32'h1, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_owner", 32'(data_rvalid_o), 32'(e[32]));
                    check("rsp_data", e[32] ? data_rdata_o : instr_rdata_o, e[31:0]);
                end
            end
            if (!instr_rvalid_o) check("instr_rdata_idle_zero", instr_rdata_o, 32'h0);
            if (!data_rvalid_o)  check("data_rdata_idle_zero", data_rdata_o, 32'h0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      32'(busy_o), 32'h0);
        check({tag, "_mem_req"},   32'(mem_req_o), 32'h0);
        check({tag, "_mem_we"},    32'(mem_we_o), 32'h0);
        check({tag, "_mem_be"},    32'(mem_be_o), 32'h0);
        check({tag, "_mem_addr"},  mem_addr_o, 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata_o, 32'h0);
        check({tag, "_gnts"},      32'({instr_gnt_o, data_gnt_o}), 32'h0);
        check({tag, "_rvalids"},   32'({instr_rvalid_o, data_rvalid_o}), 32'h0);
        check({tag, "_irdata"},    instr_rdata_o, 32'h0);
        check({tag, "_drdata"},    data_rdata_o, 32'h0);
        check({tag, "_proto_err"}, 32'(proto_err_o), 32'h0);
    endtask

    // Bound the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string exp_pat;
        rst = 1'b1;
        instr_req_i = 1'b0; instr_addr_i = 32'h0;
        data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
        data_addr_i = 32'h0; data_wdata_i = 32'h0;

        // ---- reset ----
        cyc(); cyc();
        check_all_zero("reset");
        rst = 1'b0;

        // ---- single fetch, zero-wait ----
        cyc();                                   // cycle 0
        instr_req_i = 1'b1; instr_addr_i = 32'h0000_0010;
        #1;
        check("f_instr_gnt", 32'(instr_gnt_o), 32'h1);
        check("f_data_gnt", 32'(data_gnt_o), 32'h0);
        cyc();                                   // cycle 1
        instr_req_i = 1'b0; instr_addr_i = 32'hFFFF_FFFC;
        #1;
        check("f_mem_req", 32'(mem_req_o), 32'h1);
        check("f_mem_addr", mem_addr_o, 32'h0000_0010);
        check("f_mem_we", 32'(mem_we_o), 32'h0);
        check("f_mem_be", 32'(mem_be_o), 32'hF);
        check("f_mem_wdata", mem_wdata_o, 32'h0);
        check("f_busy", 32'(busy_o), 32'h1);
        cyc();                                   // cycle 2
        #1;
        check("f_rvalid", 32'(instr_rvalid_o), 32'h1);
        check("f_rdata", instr_rdata_o, 32'h0000_0513);
        check("f_mem_req_low", 32'(mem_req_o), 32'h0);
        cyc();                                   // cycle 3
        #1;
        check("f_busy_low", 32'(busy_o), 32'h0);

        // ---- simultaneous requests ----
        cyc();                                   // cycle 0
        instr_req_i = 1'b1; instr_addr_i = 32'h0000_0014;
        data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h0000_0100;
        #1;
        check("s_data_gnt", 32'(data_gnt_o), 32'h1);
        check("s_instr_gnt0", 32'(instr_gnt_o), 32'h0);
        cyc();                                   // cycle 1
        data_req_i = 1'b0;
        #1;
        check("s_no_gnt_in_req", 32'({instr_gnt_o, data_gnt_o}), 32'h0);
        check("s_mem_addr", mem_addr_o, 32'h0000_0100);
        cyc();                                   // cycle 2
        #1;
        check("s_data_rvalid", 32'(data_rvalid_o), 32'h1);
        check("s_data_rdata", data_rdata_o, 32'hCAFE_0100);
        check("s_no_gnt_in_wait", 32'(instr_gnt_o), 32'h0);
        cyc();                                   // cycle 3
        #1;
        check("s_instr_gnt3", 32'(instr_gnt_o), 32'h1);
        cyc();                                   // cycle 4
        instr_req_i = 1'b0;
        #1;
        cyc();                                   // cycle 5
        #1;
        check("s_instr_rvalid", 32'(instr_rvalid_o), 32'h1);
        check("s_instr_rdata", instr_rdata_o, 32'h1000_0014);

        // ---- starvation guard ----
        cyc();
        log_en = 1'b1;
        instr_req_i = 1'b1; instr_addr_i = 32'h0000_0018;
        data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h0000_0104;
        repeat (33) cyc();
        instr_req_i = 1'b0; data_req_i = 1'b0;
        log_en = 1'b0;
        repeat (3) cyc();
        exp_pat = "DDDDIDDDDID";
        check("streak_len", 32'(glog.size()), 32'(exp_pat.len()));
        for (int i = 0; i < exp_pat.len() && i < glog.size(); i++)
            check($sformatf("streak_seq[%0d]", i), 32'(glog[i]), 32'(exp_pat[i]));

        // ---- store with 3 wait states ----
        gnt_delay = 3;
        cyc();                                   // cycle 0
        data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'b0011;
        data_addr_i = 32'h0000_0104; data_wdata_i = 32'hDEAD_BEEF;
        #1;
        check("st_gnt", 32'(data_gnt_o), 32'h1);
        for (int i = 0; i < 4; i++) begin
            cyc();                               // cycles 1..4 in REQ
            data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'hF;
            data_addr_i = 32'hFFFF_FFF0; data_wdata_i = 32'h0;
            #1;
            check($sformatf("st_req[%0d]", i), 32'(mem_req_o), 32'h1);
            check($sformatf("st_we[%0d]", i), 32'(mem_we_o), 32'h1);
            check($sformatf("st_be[%0d]", i), 32'(mem_be_o), 32'h3);
            check($sformatf("st_addr[%0d]", i), mem_addr_o, 32'h0000_0104);
            check($sformatf("st_wdata[%0d]", i), mem_wdata_o, 32'hDEAD_BEEF);
            check($sformatf("st_memgnt[%0d]", i), 32'(mem_gnt_i), (i == 3) ? 32'h1 : 32'h0);
        end
        cyc();                                   // cycle 5
        #1;
        check("st_rvalid", 32'(data_rvalid_o), 32'h1);
        check("st_instr_rvalid", 32'(instr_rvalid_o), 32'h0);
        gnt_delay = 0;
        cyc();
        // Read back the partially written word.
        data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h0000_0104;
        #1;
        check("ld_gnt", 32'(data_gnt_o), 32'h1);
        cyc();
        data_req_i = 1'b0;
        cyc();
        #1;
        check("ld_rvalid", 32'(data_rvalid_o), 32'h1);
        check("ld_rdata", data_rdata_o, 32'h1000_BEEF);

        // ---- spurious response in IDLE ----
        cyc();
        spur = 1'b1;
        #1;
        check("sp_rvalids", 32'({instr_rvalid_o, data_rvalid_o}), 32'h0);
        check("sp_busy0", 32'(busy_o), 32'h0);
        cyc();
        spur = 1'b0;
        #1;
        check("sp_err_high", 32'(proto_err_o), 32'h1);
        check("sp_busy1", 32'(busy_o), 32'h0);
        cyc();
        #1;
        check("sp_err_low", 32'(proto_err_o), 32'h0);

        // ---- reset in WAIT_RSP ----
        mute = 1'b1;
        cyc();                                   // cycle 0
        instr_req_i = 1'b1; instr_addr_i = 32'h0000_0010;
        #1;
        check("rw_gnt", 32'(instr_gnt_o), 32'h1);
        cyc();                                   // cycle 1
        instr_req_i = 1'b0;
        cyc();                                   // cycle 2
        #1;
        check("rw_busy", 32'(busy_o), 32'h1);
        check("rw_no_rvalid", 32'(instr_rvalid_o), 32'h0);
        cyc();                                   // cycle 3
        rst = 1'b1;
        cyc();                                   // cycle 4
        rst = 1'b0;
        mute = 1'b0;
        #1;
        check_all_zero("rw_after_rst");
        cyc();                                   // cycle 5
        spur = 1'b1;
        #1;
        check("rw_late_rvalids", 32'({instr_rvalid_o, data_rvalid_o}), 32'h0);
        cyc();                                   // cycle 6
        spur = 1'b0;
        #1;
        check("rw_late_err", 32'(proto_err_o), 32'h1);
        cyc();                                   // cycle 7
        #1;
        check("rw_late_err_low", 32'(proto_err_o), 32'h0);

        cyc();
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
